// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scan responder: FSM states, status bit
// positions, frame-result sentinel and column decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {StIdle, StCand, StHeld, StRelease} kp_state_e;

    localparam int unsigned STAT_NONEMPTY = 0;
    localparam int unsigned STAT_OVF      = 1;

    // Frame result with bit 4 set means "no single key" (none or several pressed).
    localparam logic [4:0] NO_KEY   = 5'h10;
    localparam logic [3:0] ROW_INIT = 4'b1110;

    // Number of low columns, saturated at 2.
    function automatic logic [1:0] low_count(input logic [3:0] col_n);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~col_n[i]};
        end
        return (n > 3'd2) ? 2'd2 : n[1:0];
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_responder_if.sv
// CPU-side read port of the keypad responder: pop request, status/data select and
// the 4-bit read value.
interface keypad_scan_responder_if;

    logic       ack;
    logic       statusordata;
    logic [3:0] keyout;

    modport master (output ack, output statusordata, input keyout);
    modport slave  (input ack, input statusordata, output keyout);

endinterface

// File: rtl/kp_fifo.sv
// Small 4-bit code FIFO. A push while full is accepted only if a pop happens in the
// same cycle; a pop on empty is ignored, so push+pop on empty leaves one entry.
module kp_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [3:0] data_i,
    input  logic       pop_i,
    output logic [3:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] Full = (AW + 1)'(Depth);

    logic [3:0]    mem_q [Depth];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    always_comb begin
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == Full);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || pop_i);
        head_o  = empty_o ? 4'h0 : mem_q[rptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/keypad_scan_responder.sv
// Keypad scan responder: 4x4 matrix scan, per-frame debounce FSM, code FIFO and a
// status/data read port. Define KEYPAD_AUTOREPEAT_EN to re-push a held key periodically.
module keypad_scan_responder
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned REPEAT_FRAMES  = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [3:0]                    rowwrite_o,
    input  logic [3:0]                    colread_i,
    keypad_scan_responder_if.slave        bus_if
);

    localparam logic [7:0] DebMax = 8'(DEBOUNCE_SCANS);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DEBOUNCE_SCANS == 0 ||
        DEBOUNCE_SCANS > 255 || REPEAT_FRAMES == 0 || SCAN_DIV == 16'd0) begin : g_bad_cfg
        $error("keypad_scan_responder: invalid parameter set");
    end

    logic [15:0] div_q, div_d;
    logic [1:0]  row_q, row_d;
    logic [3:0]  rowwrite_q, rowwrite_d;
    logic [1:0]  acc_cnt_q, acc_cnt_d;
    logic [3:0]  acc_code_q, acc_code_d;
    logic        sample, frame_end;
    logic [1:0]  n_low, low_idx;
    logic [2:0]  tally;
    logic [4:0]  frame_key;
    logic        key_seen, key_same;
    logic        push, pop;
    logic        fifo_full, fifo_empty;
    logic [3:0]  fifo_head;
    logic [3:0]  status;
    logic        ovf_q, ovf_d;
    logic        ack_q;
    kp_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] RepMax = 16'(REPEAT_FRAMES);
    logic [15:0] rep_q, rep_d;
`endif

    // Scan divider and per-frame tally of low columns across all four rows.
    always_comb begin
        sample     = (div_q == SCAN_DIV - 16'd1);
        frame_end  = sample && (row_q == 2'd3);
        n_low      = low_count(colread_i);
        low_idx    = low_index(colread_i);
        tally      = {1'b0, acc_cnt_q} + {1'b0, n_low};
        div_d      = sample ? 16'd0 : div_q + 16'd1;
        row_d      = sample ? row_q + 2'd1 : row_q;
        rowwrite_d = sample ? {rowwrite_q[2:0], rowwrite_q[3]} : rowwrite_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (sample) begin
            acc_cnt_d = frame_end ? 2'd0 : ((tally > 3'd2) ? 2'd2 : tally[1:0]);
            if (acc_cnt_q == 2'd0 && n_low == 2'd1) acc_code_d = {row_q, low_idx};
        end
        frame_key = NO_KEY;
        if (tally == 3'd1) begin
            frame_key = {1'b0, (acc_cnt_q == 2'd1) ? acc_code_q : {row_q, low_idx}};
        end
        key_seen = !frame_key[4];
        key_same = key_seen && (frame_key[3:0] == key_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        push    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (key_seen) begin
                        key_d = frame_key[3:0];
                        cnt_d = 8'd1;
                        if (DebMax == 8'd1) begin
                            push    = 1'b1;
                            state_d = StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = 16'd0;
`endif
                        end else begin
                            state_d = StCand;
                        end
                    end
                end
                StCand: begin
                    if (!key_seen) begin
                        state_d = StIdle;
                    end else if (key_same) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 >= DebMax) begin
                            push    = 1'b1;
                            state_d = StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = 16'd0;
`endif
                        end
                    end else begin
                        key_d = frame_key[3:0];
                        cnt_d = 8'd1;
                    end
                end
                StHeld: begin
                    if (!key_seen) begin
                        cnt_d   = 8'd1;
                        state_d = (DebMax == 8'd1) ? StIdle : StRelease;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (key_same) begin
                        rep_d = rep_q + 16'd1;
                        if (rep_q + 16'd1 >= RepMax) begin
                            push  = 1'b1;
                            rep_d = 16'd0;
                        end
                    end
`endif
                end
                StRelease: begin
                    if (!key_seen) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 >= DebMax) state_d = StIdle;
                    end else begin
                        state_d = StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = 16'd0;
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Pop on the rising edge of ack; a pop always clears overflow, even when it wins a race.
    always_comb begin
        pop   = bus_if.ack && !ack_q;
        ovf_d = ovf_q;
        if (pop) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    kp_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .data_i  (frame_key[3:0]),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= 16'd0;
            row_q      <= 2'd0;
            rowwrite_q <= ROW_INIT;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            key_q      <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q      <= 16'd0;
`endif
        end else begin
            div_q      <= div_d;
            row_q      <= row_d;
            rowwrite_q <= rowwrite_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            ack_q      <= bus_if.ack;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    always_comb begin
        status                = 4'h0;
        status[STAT_NONEMPTY] = !fifo_empty;
        status[STAT_OVF]      = ovf_q;
        if (reset) begin
            bus_if.keyout = 4'h0;
        end else if (bus_if.statusordata) begin
            bus_if.keyout = status;
        end else begin
            bus_if.keyout = fifo_head;
        end
    end

    assign rowwrite_o = rowwrite_q;

endmodule
